stopwatch_core: RTL and testbench

Time-base and control block that produces the four BCD digits shown by the multiplexed 7-segment display driver. It counts minutes, tens of seconds, seconds and tenths from the 100 MHz system clock. It debounces the raw board buttons and runs a start/pause/clear state machine. hex3..hex0 connect directly to the display driver's digit inputs. Decimal points sit after hex3 and after hex1, giving the format M.SS.t.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_core_button_debounce.sv | 51 +++++
 rtl/stopwatch_core.sv | 144 ++++++++++++++
 tb/tb_stopwatch_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: run-state encoding, BCD digit type
// and the per-digit rollover limits (tenths, seconds, tens of seconds, minutes).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIG0_MAX = 4'd9;
    localparam bcd_t DIG1_MAX = 4'd9;
    localparam bcd_t DIG2_MAX = 4'd5;
    localparam bcd_t DIG3_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_core_button_debounce.sv
// Raw button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press pulse on the accepted rising level. Accepted releases produce no pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_accept;

    // r_cnt holds how many earlier cycles the synchronized level has disagreed with r_level
    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_sync2;
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time base: debounced start/clear control, prescaled M.SS.t BCD counter.
// Define STOPWATCH_LAP_EN to add the lap-hold display freeze driven by btn_lap.
module stopwatch_core #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic       running,
    output logic       overflow
);
    import stopwatch_pkg::*;

    // state   | meaning
    // IDLE    | digits zero, stopped
    // RUN     | prescaler advancing, digits count
    // PAUSE   | prescaler and digits frozen, fraction kept

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);

    sw_state_t        r_state;
    sw_state_t        w_state_nxt;
    logic             r_running;
    logic             r_overflow;
    logic [PRE_W-1:0] r_pre;
    bcd_t             r_dig3, r_dig2, r_dig1, r_dig0;
    logic             w_start, w_clear;
    logic             w_tick;
    logic             w_c0, w_c1, w_c2, w_c3;
    logic [15:0]      w_live;
    logic [15:0]      w_show;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clock(clock), .reset_n(reset_n), .i_btn(btn_start), .o_press(w_start)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clock(clock), .reset_n(reset_n), .i_btn(btn_clear), .o_press(w_clear)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_TERM);
    assign w_c0   = (r_dig0 == DIG0_MAX);
    assign w_c1   = w_c0 && (r_dig1 == DIG1_MAX);
    assign w_c2   = w_c1 && (r_dig2 == DIG2_MAX);
    assign w_c3   = w_c2 && (r_dig3 == DIG3_MAX);

    // A tick coinciding with a start press still increments; the FSM pauses afterwards
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre      <= '0;
            r_dig3     <= '0;
            r_dig2     <= '0;
            r_dig1     <= '0;
            r_dig0     <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_pre      <= '0;
            r_dig3     <= '0;
            r_dig2     <= '0;
            r_dig1     <= '0;
            r_dig0     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
            end
            if (w_tick) begin
                r_dig0 <= w_c0 ? '0 : r_dig0 + 4'd1;
                if (w_c0) r_dig1 <= w_c1 ? '0 : r_dig1 + 4'd1;
                if (w_c1) r_dig2 <= w_c2 ? '0 : r_dig2 + 4'd1;
                if (w_c2) r_dig3 <= w_c3 ? '0 : r_dig3 + 4'd1;
                if (w_c3) r_overflow <= 1'b1;
            end
        end
    end

    assign w_live = {r_dig3, r_dig2, r_dig1, r_dig0};

`ifdef STOPWATCH_LAP_EN
    logic        w_lap;
    logic        r_lap_hold;
    logic [15:0] r_lap_dig;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clock(clock), .reset_n(reset_n), .i_btn(btn_lap), .o_press(w_lap)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lap_hold <= 1'b0;
            r_lap_dig  <= '0;
        end else if (w_clear) begin
            r_lap_hold <= 1'b0;
        end else if (w_lap && (r_state != ST_IDLE)) begin
            r_lap_hold <= !r_lap_hold;
            if (!r_lap_hold) r_lap_dig <= w_live;
        end
    end

    assign w_show = r_lap_hold ? r_lap_dig : w_live;
`else
    logic w_unused_lap;
    assign w_unused_lap = btn_lap;
    assign w_show       = w_live;
`endif

    assign {hex3, hex2, hex1, hex0} = w_show;
    assign running  = r_running;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: tenths-count model compared every cycle, plus literal checkpoints.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DEB     = 4;
    localparam int PER     = CLK_HZ / TICK_HZ;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap   = 1'b0;
    logic [3:0] hex3, hex2, hex1, hex0;
    logic       running, overflow;

    int checks   = 0;
    int failures = 0;

    stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock), .reset_n(reset_n),
        .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .running(running), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Model: elapsed time as a plain tenths count; state 0=idle 1=run 2=pause.
    // Buttons: a press is seen when the last DEB synchronized samples are all high.
    int             m_state  = 0;
    int             m_pre    = 0;
    int             m_tenths = 0;
    int             m_lap    = 0;
    bit             m_ovf    = 1'b0;
    bit             m_hold   = 1'b0;
    logic [2:0]     m_h1     = '0;
    logic [2:0]     m_h2     = '0;
    logic [2:0]     m_acc    = '0;
    logic [2:0]     m_p      = '0;
    logic [DEB-1:0] m_win [3];

    always @(posedge clock or negedge reset_n) begin
        logic [DEB-1:0] w;
        if (!reset_n) begin
            m_state <= 0; m_pre <= 0; m_tenths <= 0; m_lap <= 0;
            m_ovf <= 1'b0; m_hold <= 1'b0;
            m_h1 <= '0; m_h2 <= '0; m_acc <= '0; m_p <= '0;
            for (int b = 0; b < 3; b++) m_win[b] <= '0;
        end else begin
            if (m_p[1]) begin
                m_state <= 0; m_pre <= 0; m_tenths <= 0; m_ovf <= 1'b0; m_hold <= 1'b0;
            end else begin
                if (m_state == 1) begin
                    if (m_pre == PER - 1) begin
                        m_pre <= 0;
                        if (m_tenths == 5999) begin
                            m_tenths <= 0;
                            m_ovf    <= 1'b1;
                        end else begin
                            m_tenths <= m_tenths + 1;
                        end
                    end else begin
                        m_pre <= m_pre + 1;
                    end
                end
                if (m_p[0]) m_state <= (m_state == 1) ? 2 : 1;
`ifdef STOPWATCH_LAP_EN
                if (m_p[2] && m_state != 0) begin
                    m_hold <= !m_hold;
                    if (!m_hold) m_lap <= m_tenths;
                end
`endif
            end
            for (int b = 0; b < 3; b++) begin
                w = {m_win[b][DEB-2:0], m_h2[b]};
                m_win[b] <= w;
                m_p[b]   <= 1'b0;
                if (w == {DEB{1'b1}} && !m_acc[b]) begin
                    m_acc[b] <= 1'b1;
                    m_p[b]   <= 1'b1;
                end else if (w == '0 && m_acc[b]) begin
                    m_acc[b] <= 1'b0;
                end
            end
            m_h2 <= m_h1;
            m_h1 <= {btn_lap, btn_clear, btn_start};
        end
    end

    function automatic logic [15:0] bcd_of(int t);
        int s;
        s = (t / 10) % 60;
        return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [17:0] act, exp;
        @(negedge clock);
        #1;
        exp = {bcd_of(m_hold ? m_lap : m_tenths), (m_state == 1), m_ovf};
        act = {hex3, hex2, hex1, hex0, running, overflow};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL cycle_compare at %0t: dut hex=%h run=%b ovf=%b, model hex=%h run=%b ovf=%b",
                     $time, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    task automatic wait_tenths(int target, int budget);
        int n;
        n = 0;
        while (m_tenths != target && n < budget) begin
            step();
            n++;
        end
        chk("wait_tenths_reached", m_tenths, target);
    endtask

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("reset_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
        chk("reset_running", running, 0);
        chk("reset_overflow", overflow, 0);
        repeat (200) step();

        btn_start = 1'b1;
        repeat (2) step();
        btn_start = 1'b0;
        repeat (20) step();
        chk("glitch_no_start", running, 0);

        btn_start = 1'b1;
        repeat (10) step();
        btn_start = 1'b0;
        repeat (55) step();
        chk("five_ticks_hex", {hex3, hex2, hex1, hex0}, 16'h0005);
        chk("five_ticks_running", running, 1);

        wait_tenths(600, 7000);
        chk("one_minute_hex", {hex3, hex2, hex1, hex0}, 16'h1000);
        btn_start = 1'b1;
        repeat (10) step();
        btn_start = 1'b0;
        repeat (100) step();
        chk("paused_running", running, 0);
        chk("paused_hex", {hex3, hex2, hex1, hex0}, 16'h1000);

        btn_start = 1'b1;
        repeat (9) step();
        chk("resume_running", running, 1);
        chk("resume_fraction_hold", {hex3, hex2, hex1, hex0}, 16'h1000);
        step();
        chk("resume_fraction_kept", {hex3, hex2, hex1, hex0}, 16'h1001);
        btn_start = 1'b0;

        wait_tenths(5999, 60000);
        chk("max_hex", {hex3, hex2, hex1, hex0}, 16'h9599);
        chk("max_overflow", overflow, 0);
        repeat (10) step();
        chk("wrap_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
        chk("wrap_overflow", overflow, 1);
        chk("wrap_running", running, 1);

        btn_clear = 1'b1;
        repeat (10) step();
        btn_clear = 1'b0;
        repeat (10) step();
        chk("clear_overflow", overflow, 0);
        chk("clear_running", running, 0);
        chk("clear_hex", {hex3, hex2, hex1, hex0}, 16'h0000);

        btn_start = 1'b1;
        repeat (10) step();
        btn_start = 1'b0;
        repeat (30) step();
        chk("restart_running", running, 1);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        repeat (10) step();
        chk("both_running", running, 0);
        chk("both_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        repeat (10) step();

        btn_start = 1'b1;
        repeat (10) step();
        btn_start = 1'b0;
        repeat (40) step();
        chk("pre_reset_hex", {hex3, hex2, hex1, hex0}, 16'h0004);
        reset_n = 1'b0;
        #1;
        chk("async_reset_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
        chk("async_reset_running", running, 0);
        step();
        reset_n = 1'b1;
        repeat (10) step();

`ifdef STOPWATCH_LAP_EN
        btn_start = 1'b1;
        repeat (10) step();
        btn_start = 1'b0;
        wait_tenths(32, 1000);
        btn_lap = 1'b1;
        repeat (10) step();
        btn_lap = 1'b0;
        wait_tenths(50, 1000);
        chk("lap_frozen_hex", {hex3, hex2, hex1, hex0}, 16'h0032);
        chk("lap_running", running, 1);
        btn_lap = 1'b1;
        repeat (8) step();
        chk("lap_release_hex", {hex3, hex2, hex1, hex0}, 16'h0050);
        btn_lap = 1'b0;
        repeat (10) step();
`else
        btn_lap = 1'b1;
        repeat (10) step();
        btn_lap = 1'b0;
        repeat (20) step();
        chk("lap_ignored_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
